mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
Shares one memory bus between the CPU's instruction-fetch port and data port, so the core can run on a single-port (von Neumann) memory system. Sits between the control/data paths and the external bus. Each transaction is sequenced with a waitrequest handshake. Stall signals back to the core freeze the pipeline until each request completes. Fixed priority goes to data, with a starvation guard for fetch.

Parameters:
- ADDR_W, 32, address width for both requesters and the bus.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- MAX_DATA_BURST, 4, maximum consecutive data grants while a fetch is pending before fetch is forced. Legal range 1..15.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- instr_read  in  1  fetch request; held until instr_stall is low.
- instr_addr  in  ADDR_W  fetch address.
- instr_readdata  out  DATA_W  fetched word; valid when instr_read=1 and instr_stall=0.
- instr_stall  out  1  fetch not yet complete.
- data_read  in  1  load request; held until data_stall is low.
- data_write  in  1  store request; held until data_stall is low.
- data_addr  in  ADDR_W  load/store address.
- data_writedata  in  DATA_W  store data.
- data_byteenable  in  DATA_W/8  store/load byte lanes.
- data_readdata  out  DATA_W  load data; valid when data_read=1 and data_stall=0.
- data_stall  out  1  data access not yet complete.
- bus_address  out  ADDR_W  bus address.
- bus_read  out  1  bus read strobe.
- bus_write  out  1  bus write strobe.
- bus_writedata  out  DATA_W  bus write data.
- bus_byteenable  out  DATA_W/8  bus byte lanes. Set to all ones for fetch.
- bus_readdata  in  DATA_W  bus read data; valid in the cycle where waitrequest=0.
- bus_waitrequest  in  1  high means the slave has not accepted or completed the access.

Behaviour:
- FSM states: IDLE, INSTR, DATA, RECOVER. All bus outputs are driven from registers.
- Reset values: state=IDLE; bus_read=0, bus_write=0; bus_address, bus_writedata and readdata-related registers =0; bus_byteenable=0; streak counter=0. Reset is asynchronous, so strobes drop within the same cycle, including mid-transaction. No completion is signalled for an aborted access.
- Arbitration happens in IDLE only, on the current cycle's requests. At the clock edge the winner's address, writedata and byteenable are latched and the strobe is registered. This gives a one-cycle request-to-strobe latency.
- Priority rule 1: if only one requester is pending, it wins.
- Priority rule 2: if both are pending, data wins unless streak==MAX_DATA_BURST, in which case fetch wins.
- Streak counter:
  - increments on a data grant while instr_read=1;
  - clears on any fetch grant;
  - clears in any IDLE cycle where instr_read=0;
  - saturates at MAX_DATA_BURST.
- If data_read and data_write are both high, the access is a write only (bus_read=0).
- INSTR/DATA: the strobe and latched fields stay stable while bus_waitrequest=1. The completion cycle is the one with bus_waitrequest=0.
- In the completion cycle, the owner's stall=0 and its readdata is bus_readdata passed through combinationally. The next state is RECOVER and the strobe deasserts at the edge.
- RECOVER lasts one cycle, then returns to IDLE. Requests are ignored in RECOVER, so a completed request that is still asserted cannot be re-granted.
- Minimum cost is 3 cycles per access with zero-wait memory.
- Stall equations:
  - instr_stall = instr_read & ~(state==INSTR & ~bus_waitrequest).
  - data_stall = (data_read|data_write) & ~(state==DATA & ~bus_waitrequest).
- Outside completion cycles, instr_readdata and data_readdata are 0.
- Requesters must hold address and data stable while stalled. Input changes during INSTR/DATA are ignored because the fields are latched.
- A requester that drops its request mid-transaction does not abort the bus access. The access completes and no stall-low is seen.

Test Plan:
- Single fetch, addr 0xBFC00000, waitrequest=0, bus_readdata 0x2402000A.
  - Cycle 1: bus_read=1, bus_address=0xBFC00000, bus_byteenable=0xF.
  - Cycle 1: instr_stall=0 and instr_readdata=0x2402000A.
  - Cycle 2: RECOVER with bus_read=0.
- Same-cycle data_read at 0x00001000 and fetch at 0xBFC00004 → data is granted first and data_stall falls in cycle 1. Fetch strobe appears in cycle 4. instr_stall stays high through cycle 3.
- Store of 0xDEADBEEF, byteenable 0x3, to 0x2000 with waitrequest high for 3 cycles → bus_write, address, data and byteenable are held stable for 4 cycles. data_stall is low only in the 4th.
- Continuous data and fetch requests with MAX_DATA_BURST=4 → grant order is D,D,D,D,I,D,D,D,D,I.
- Reset asserted while bus_write=1 with waitrequest high → bus_write=0 in the same cycle and data_stall is never low. After release the state is IDLE and the pending request is re-granted.
- data_read=1 and data_write=1 together → only bus_write is asserted and data_readdata=0 at completion.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between instruction fetch and data ports; fixed data priority with a fetch starvation guard.
// One cycle from request to bus strobe, one RECOVER cycle after completion; requesters stall until their access completes.
module mem_bus_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  instr_read,
  input  logic [ADDR_W-1:0]     instr_addr,
  output logic [DATA_W-1:0]     instr_readdata,
  output logic                  instr_stall,
  input  logic                  data_read,
  input  logic                  data_write,
  input  logic [ADDR_W-1:0]     data_addr,
  input  logic [DATA_W-1:0]     data_writedata,
  input  logic [DATA_W/8-1:0]   data_byteenable,
  output logic [DATA_W-1:0]     data_readdata,
  output logic                  data_stall,
  output logic [ADDR_W-1:0]     bus_address,
  output logic                  bus_read,
  output logic                  bus_write,
  output logic [DATA_W-1:0]     bus_writedata,
  output logic [DATA_W/8-1:0]   bus_byteenable,
  input  logic [DATA_W-1:0]     bus_readdata,
  input  logic                  bus_waitrequest
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_BURST);

  typedef enum logic [1:0] {IDLE, INSTR, DATA, RECOVER} state_t;

  state_t     state;
  logic [3:0] streak;
  logic       data_req;
  logic       streak_max;
  logic       grant_data;
  logic       grant_instr;
  logic       instr_done;
  logic       data_done;

  assign data_req    = data_read | data_write;
  assign streak_max  = (streak == STREAK_MAX);
  assign grant_data  = data_req & (~instr_read | ~streak_max);
  assign grant_instr = instr_read & (~data_req | streak_max);
  assign instr_done  = (state == INSTR) & ~bus_waitrequest;
  assign data_done   = (state == DATA) & ~bus_waitrequest;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      streak         <= '0;
      bus_address    <= '0;
      bus_read       <= 1'b0;
      bus_write      <= 1'b0;
      bus_writedata  <= '0;
      bus_byteenable <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_data) begin
            state          <= DATA;
            bus_address    <= data_addr;
            bus_writedata  <= data_writedata;
            bus_byteenable <= data_byteenable;
            bus_write      <= data_write;
            // A simultaneous read+write request is treated as a write only.
            bus_read       <= data_read & ~data_write;
            if (!instr_read)
              streak <= '0;
            else if (!streak_max)
              streak <= streak + 4'd1;
          end else if (grant_instr) begin
            state          <= INSTR;
            bus_address    <= instr_addr;
            bus_byteenable <= '1;
            bus_read       <= 1'b1;
            bus_write      <= 1'b0;
            streak         <= '0;
          end else if (!instr_read) begin
            streak <= '0;
          end
        end
        INSTR, DATA: begin
          if (!bus_waitrequest) begin
            state     <= RECOVER;
            bus_read  <= 1'b0;
            bus_write <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign instr_stall    = instr_read & ~instr_done;
  assign data_stall     = data_req & ~data_done;
  assign instr_readdata = instr_done ? bus_readdata : '0;
  assign data_readdata  = (data_done & bus_read) ? bus_readdata : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: fetch, priority, wait states, starvation guard, reset abort, read+write.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_read;
  logic [31:0] instr_addr;
  logic [31:0] instr_readdata;
  logic        instr_stall;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_addr;
  logic [31:0] data_writedata;
  logic [3:0]  data_byteenable;
  logic [31:0] data_readdata;
  logic        data_stall;
  logic [31:0] bus_address;
  logic        bus_read;
  logic        bus_write;
  logic [31:0] bus_writedata;
  logic [3:0]  bus_byteenable;
  logic [31:0] bus_readdata;
  logic        bus_waitrequest;

  int passed = 0;
  int total  = 0;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DATA_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .instr_read(instr_read), .instr_addr(instr_addr),
    .instr_readdata(instr_readdata), .instr_stall(instr_stall),
    .data_read(data_read), .data_write(data_write), .data_addr(data_addr),
    .data_writedata(data_writedata), .data_byteenable(data_byteenable),
    .data_readdata(data_readdata), .data_stall(data_stall),
    .bus_address(bus_address), .bus_read(bus_read), .bus_write(bus_write),
    .bus_writedata(bus_writedata), .bus_byteenable(bus_byteenable),
    .bus_readdata(bus_readdata), .bus_waitrequest(bus_waitrequest)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    logic [9:0] exp_order;
    int         grants;

    reset = 1'b1;
    instr_read = 0; instr_addr = '0;
    data_read = 0; data_write = 0; data_addr = '0;
    data_writedata = '0; data_byteenable = '0;
    bus_readdata = '0; bus_waitrequest = 1'b0;
    #1;
    chk("rst_bus_read", 32'(bus_read), 32'd0);
    chk("rst_bus_write", 32'(bus_write), 32'd0);
    chk("rst_bus_address", bus_address, 32'h0);
    chk("rst_bus_be", 32'(bus_byteenable), 32'h0);
    chk("rst_bus_wdata", bus_writedata, 32'h0);
    tick();
    reset = 1'b0;
    tick();

    // Single fetch with zero wait states
    instr_read = 1; instr_addr = 32'hBFC00000; bus_readdata = 32'h2402000A;
    #1;
    chk("f_c0_istall", 32'(instr_stall), 32'd1);
    chk("f_c0_bus_read", 32'(bus_read), 32'd0);
    tick(); #1;
    chk("f_c1_bus_read", 32'(bus_read), 32'd1);
    chk("f_c1_addr", bus_address, 32'hBFC00000);
    chk("f_c1_be", 32'(bus_byteenable), 32'hF);
    chk("f_c1_istall", 32'(instr_stall), 32'd0);
    chk("f_c1_irdata", instr_readdata, 32'h2402000A);
    chk("f_c1_drdata", data_readdata, 32'h0);
    instr_read = 0;
    tick(); #1;
    chk("f_c2_bus_read", 32'(bus_read), 32'd0);
    chk("f_c2_irdata", instr_readdata, 32'h0);
    tick();

    // Simultaneous data read and fetch: data first
    data_read = 1; data_addr = 32'h00001000; data_byteenable = 4'hF;
    instr_read = 1; instr_addr = 32'hBFC00004; bus_readdata = 32'h11112222;
    tick(); #1;
    chk("p_c1_addr", bus_address, 32'h00001000);
    chk("p_c1_bus_read", 32'(bus_read), 32'd1);
    chk("p_c1_dstall", 32'(data_stall), 32'd0);
    chk("p_c1_drdata", data_readdata, 32'h11112222);
    chk("p_c1_istall", 32'(instr_stall), 32'd1);
    data_read = 0;
    tick(); #1;
    chk("p_c2_istall", 32'(instr_stall), 32'd1);
    chk("p_c2_bus_read", 32'(bus_read), 32'd0);
    tick(); #1;
    chk("p_c3_istall", 32'(instr_stall), 32'd1);
    chk("p_c3_bus_read", 32'(bus_read), 32'd0);
    tick(); #1;
    chk("p_c4_bus_read", 32'(bus_read), 32'd1);
    chk("p_c4_addr", bus_address, 32'hBFC00004);
    chk("p_c4_istall", 32'(instr_stall), 32'd0);
    instr_read = 0;
    tick();
    tick();

    // Store with three wait cycles; a mid-access address change must be ignored
    data_write = 1; data_addr = 32'h2000; data_writedata = 32'hDEADBEEF;
    data_byteenable = 4'h3; bus_waitrequest = 1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c == 2) data_addr = 32'h3000;
      #1;
      chk($sformatf("s_c%0d_write", c), 32'(bus_write), 32'd1);
      chk($sformatf("s_c%0d_addr", c), bus_address, 32'h2000);
      chk($sformatf("s_c%0d_wdata", c), bus_writedata, 32'hDEADBEEF);
      chk($sformatf("s_c%0d_be", c), 32'(bus_byteenable), 32'h3);
      chk($sformatf("s_c%0d_dstall", c), 32'(data_stall), 32'd1);
    end
    tick();
    bus_waitrequest = 0;
    #1;
    chk("s_c4_write", 32'(bus_write), 32'd1);
    chk("s_c4_addr", bus_address, 32'h2000);
    chk("s_c4_dstall", 32'(data_stall), 32'd0);
    data_write = 0; data_addr = 32'h2000;
    tick(); #1;
    chk("s_c5_write", 32'(bus_write), 32'd0);
    tick();

    // Starvation guard: continuous requests from both sides
    exp_order = 10'b1111011110;
    grants = 0;
    data_read = 1; data_addr = 32'h4000;
    instr_read = 1; instr_addr = 32'h8000;
    for (int c = 0; c < 40 && grants < 10; c++) begin
      tick(); #1;
      if (bus_read) begin
        chk($sformatf("burst_grant%0d", grants), 32'(bus_address == 32'h4000),
            32'(exp_order[9-grants]));
        grants++;
      end
    end
    chk("burst_grant_count", 32'(grants), 32'd10);
    data_read = 0; instr_read = 0;
    tick();
    tick();
    tick();

    // Reset during a waited write aborts it without completion
    data_write = 1; data_addr = 32'h5000; data_writedata = 32'h55AA55AA;
    data_byteenable = 4'hF; bus_waitrequest = 1;
    tick(); #1;
    chk("r_write_before", 32'(bus_write), 32'd1);
    reset = 1;
    #1;
    chk("r_write_async", 32'(bus_write), 32'd0);
    chk("r_dstall_async", 32'(data_stall), 32'd1);
    bus_waitrequest = 0;
    #1;
    chk("r_dstall_nowait", 32'(data_stall), 32'd1);
    tick();
    chk("r_write_held", 32'(bus_write), 32'd0);
    chk("r_dstall_held", 32'(data_stall), 32'd1);
    reset = 0;
    tick(); #1;
    chk("r_regrant_write", 32'(bus_write), 32'd1);
    chk("r_regrant_addr", bus_address, 32'h5000);
    chk("r_regrant_dstall", 32'(data_stall), 32'd0);
    data_write = 0;
    tick();
    tick();

    // Read and write together behave as a write only
    data_read = 1; data_write = 1; data_addr = 32'h6000;
    data_writedata = 32'h12345678; data_byteenable = 4'hF; bus_readdata = 32'hCAFEF00D;
    tick(); #1;
    chk("rw_write", 32'(bus_write), 32'd1);
    chk("rw_read", 32'(bus_read), 32'd0);
    chk("rw_dstall", 32'(data_stall), 32'd0);
    chk("rw_drdata", data_readdata, 32'h0);
    data_read = 0; data_write = 0;
    tick(); #1;
    chk("rw_recover_write", 32'(bus_write), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
